// File: rtl/msrv32_load_pkg.sv
// Shared constants for the MSRV32 load-data alignment unit.
// Load-size encodings match the funct3[1:0] field of RV32I loads.
package msrv32_load_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/msrv32_load_extract.sv
// Combinational lane select and zero/sign extension of a little-endian load word.
// Misaligned halfwords are not trapped; bit 0 of the offset is ignored for them.
module msrv32_load_extract
  import msrv32_load_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic            load_unsigned,
  input  logic [1:0]      load_size,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_fill;
  logic        half_fill;

  always_comb begin
    byte_sel = data[7:0];
    case (offset)
      2'b00:   byte_sel = data[7:0];
      2'b01:   byte_sel = data[15:8];
      2'b10:   byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
  end

  assign half_sel  = offset[1] ? data[31:16] : data[15:0];
  assign byte_fill = ~load_unsigned & byte_sel[7];
  assign half_fill = ~load_unsigned & half_sel[15];

  // Size 11 has no meaning in RV32I; it falls into the word path.
  always_comb begin
    result = data;
    case (load_size)
      LS_BYTE: result = {{24{byte_fill}}, byte_sel};
      LS_HALF: result = {{16{half_fill}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/msrv32_load_unit.sv
// Writeback-stage load unit: extracts and extends the addressed data and
// registers it, holding the previous result while the AHB bus reports wait/error.
module msrv32_load_unit
  import msrv32_load_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            ahb_resp_in,
  input  logic [XLEN-1:0] ms_riscv32_mp_dmdata_in,
  input  logic [1:0]      iadder_out_1_to_0_in,
  input  logic            load_unsigned_in,
  input  logic [1:0]      load_size_in,
  output logic [XLEN-1:0] lu_output_out
);

  logic [XLEN-1:0] lu_next;

  msrv32_load_extract u_extract (
    .data          (ms_riscv32_mp_dmdata_in),
    .offset        (iadder_out_1_to_0_in),
    .load_unsigned (load_unsigned_in),
    .load_size     (load_size_in),
    .result        (lu_next)
  );

  // A high AHB response means the read data is not valid yet, so keep the last result.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      lu_output_out <= '0;
    end else if (!ahb_resp_in) begin
      lu_output_out <= lu_next;
    end
  end

endmodule

// File: tb/tb_msrv32_load_unit.sv
// Self-checking bench for msrv32_load_unit: directed vector table, hand-written
// reset/hold sequences, and randomized traffic against a behavioural model.
module tb_msrv32_load_unit;

  logic        clk;
  logic        rst;
  logic        ahb_resp;
  logic [31:0] dmdata;
  logic [1:0]  offset;
  logic        load_unsigned;
  logic [1:0]  load_size;
  logic [31:0] lu_output;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] dm;
    logic [1:0]  off;
    logic        uns;
    logic [1:0]  size;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  msrv32_load_unit dut (
    .ms_riscv32_mp_clk_in    (clk),
    .ms_riscv32_mp_rst_in    (rst),
    .ahb_resp_in             (ahb_resp),
    .ms_riscv32_mp_dmdata_in (dmdata),
    .iadder_out_1_to_0_in    (offset),
    .load_unsigned_in        (load_unsigned),
    .load_size_in            (load_size),
    .lu_output_out           (lu_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift the addressed lane down to bit 0, mask, then extend.
  function automatic logic [31:0] ref_load(logic [31:0] dm, logic [1:0] off,
                                           logic uns, logic [1:0] size);
    logic [31:0] v;
    int unsigned shift;
    if (size >= 2) return dm;
    if (size == 0) begin
      shift = 8 * int'(off);
      v = (dm >> shift) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      shift = (off >= 2) ? 16 : 0;
      v = (dm >> shift) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (lu_output !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%08h expected=%08h", name, lu_output, exp);
    end
  endtask

  // Drives one input set and advances to just after the next rising edge.
  task automatic applyStimulus(input logic [31:0] dm, input logic [1:0] off,
                               input logic uns, input logic [1:0] size,
                               input logic resp);
    dmdata        = dm;
    offset        = off;
    load_unsigned = uns;
    load_size     = size;
    ahb_resp      = resp;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_q;
  logic [31:0] r_dm;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_resp;
  logic        r_rst;

  initial begin
    rst = 1'b0; ahb_resp = 1'b0; dmdata = '0; offset = '0;
    load_unsigned = 1'b0; load_size = '0;

    vecs.push_back('{"lb_off0",    32'h12345678, 2'b00, 1'b0, 2'b00, 32'h0000_0078});
    vecs.push_back('{"lbu_off1",   32'h12345678, 2'b01, 1'b1, 2'b00, 32'h0000_0056});
    vecs.push_back('{"lb_off2",    32'h12345678, 2'b10, 1'b0, 2'b00, 32'h0000_0034});
    vecs.push_back('{"lbu_off3",   32'h12345678, 2'b11, 1'b1, 2'b00, 32'h0000_0012});
    vecs.push_back('{"lh_off0",    32'h12345678, 2'b00, 1'b0, 2'b01, 32'h0000_5678});
    vecs.push_back('{"lhu_off2",   32'h12345678, 2'b10, 1'b1, 2'b01, 32'h0000_1234});
    vecs.push_back('{"lw_size10",  32'h12345678, 2'b00, 1'b0, 2'b10, 32'h1234_5678});
    vecs.push_back('{"lw_size11",  32'h12345678, 2'b01, 1'b0, 2'b11, 32'h1234_5678});
    vecs.push_back('{"lb_neg",     32'h80FF7F80, 2'b00, 1'b0, 2'b00, 32'hFFFF_FF80});
    vecs.push_back('{"lbu_neg",    32'h80FF7F80, 2'b00, 1'b1, 2'b00, 32'h0000_0080});
    vecs.push_back('{"lb_off1_pos",32'h80FF7F80, 2'b01, 1'b0, 2'b00, 32'h0000_007F});
    vecs.push_back('{"lh_neg",     32'h80FF7F80, 2'b10, 1'b0, 2'b01, 32'hFFFF_80FF});
    vecs.push_back('{"lhu_neg",    32'h80FF7F80, 2'b10, 1'b1, 2'b01, 32'h0000_80FF});
    vecs.push_back('{"lh_mis1",    32'h12345678, 2'b01, 1'b0, 2'b01, 32'h0000_5678});
    vecs.push_back('{"lh_mis3",    32'h12345678, 2'b11, 1'b0, 2'b01, 32'h0000_1234});

    // Reset asserted without any clock edge must clear the output at once.
    #1;
    dmdata = 32'h12345678; load_size = 2'b10; rst = 1'b1;
    #1;
    checkOutput("reset_async", 32'h0);
    @(posedge clk); #1;
    checkOutput("reset_held", 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("reset_release_no_edge", 32'h0);
    @(posedge clk); #1;
    checkOutput("first_edge_after_reset", 32'h1234_5678);

    // Table vectors: each result appears one clock after the input change.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dm, vecs[i].off, vecs[i].uns, vecs[i].size, 1'b0);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Hold while the bus reports wait/error, then resume.
    applyStimulus(32'h12345678, 2'b00, 1'b0, 2'b10, 1'b0);
    checkOutput("hold_setup", 32'h1234_5678);
    applyStimulus(32'hDEADBEEF, 2'b00, 1'b0, 2'b10, 1'b1);
    checkOutput("hold_cycle1", 32'h1234_5678);
    applyStimulus(32'hDEADBEEF, 2'b00, 1'b0, 2'b10, 1'b1);
    checkOutput("hold_cycle2", 32'h1234_5678);
    applyStimulus(32'hDEADBEEF, 2'b00, 1'b0, 2'b10, 1'b0);
    checkOutput("hold_release", 32'hDEAD_BEEF);

    // Reset mid-stream discards the pending result.
    dmdata = 32'hCAFE_F00D;
    rst = 1'b1;
    #1;
    checkOutput("midstream_reset_async", 32'h0);
    @(posedge clk); #1;
    checkOutput("midstream_reset_discard", 32'h0);
    rst = 1'b0;
    applyStimulus(32'hCAFE_F00D, 2'b11, 1'b0, 2'b00, 1'b0);
    checkOutput("after_midstream_reset", 32'hFFFF_FFCA);

    // Randomized traffic with occasional wait states and resets.
    model_q = lu_output === 32'hFFFF_FFCA ? 32'hFFFF_FFCA : 32'hFFFF_FFCA;
    for (int n = 0; n < 400; n++) begin
      r_dm   = $urandom;
      r_off  = 2'($urandom_range(0, 3));
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_resp = ($urandom_range(0, 3) == 0);
      r_rst  = ($urandom_range(0, 31) == 0);
      rst = r_rst;
      if (r_rst)       model_q = 32'h0;
      else if (!r_resp) model_q = ref_load(r_dm, r_off, r_uns, r_size);
      applyStimulus(r_dm, r_off, r_uns, r_size, r_resp);
      checkOutput($sformatf("random_%0d", n), model_q);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_load_unit.md
Name: msrv32_load_unit

Overview:
- Load-data alignment and extension unit for the MSRV32 RV32I core.
- Sits in the writeback stage, between the AHB data-memory read bus and the register-file write mux.
- Selects the byte, halfword or word addressed by the low effective-address bits.
- Zero- or sign-extends the selection to 32 bits and presents it on a registered output that holds during bus wait/error.

Parameters:
- XLEN, 32, data path width; only 32 is supported.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- ahb_resp_in  input  1  AHB response. 0 = data valid / OKAY; 1 = wait or error, data invalid.
- ms_riscv32_mp_dmdata_in  input  32  raw data-memory read word (little-endian).
- iadder_out_1_to_0_in  input  2  effective address bits [1:0].
- load_unsigned_in  input  1  1 = zero-extend (LBU/LHU); 0 = sign-extend (LB/LH).
- load_size_in  input  2  00 = byte, 01 = halfword, 10 = word, 11 = word.
- lu_output_out  output  32  extended load result (registered).

Behaviour:
- Reset: while ms_riscv32_mp_rst_in is high, lu_output_out = 32'h0000_0000 immediately (asynchronous); 0 is held until the first valid clock edge after deassertion.
- Combinational next-value computation, byte lane:
  - offset 00 selects [7:0]; 01 selects [15:8]; 10 selects [23:16]; 11 selects [31:24].
  - result = {24{fill}, byte}.
- Halfword lane:
  - iadder bit1 = 0 selects [15:0]; bit1 = 1 selects [31:16].
  - Bit0 is ignored; misaligned halfwords are not trapped here.
  - result = {16{fill}, half}.
- Word: result = full input word; iadder bits and load_unsigned_in are ignored.
- Fill bit: 0 when load_unsigned_in = 1; otherwise the MSB of the selected byte or halfword.
- load_size_in = 11 is decoded identically to 10.
- Register update, on each rising clock edge when not in reset:
  - ahb_resp_in = 0: lu_output_out <= computed value.
  - ahb_resp_in = 1: lu_output_out holds its previous value.
- Latency: exactly 1 clock from stable inputs with ahb_resp_in = 0 to lu_output_out.
- No handshake beyond ahb_resp_in; the unit accepts a new input set every cycle.
- Reset asserted mid-stream: the output clears at once; the pending result is discarded.
- No X propagation: every size/offset combination yields a defined value.

Decomposition:
- Package msrv32_load_pkg:
  - load-size constants LS_BYTE = 2'b00, LS_HALF = 2'b01, LS_WORD = 2'b10.
  - XLEN constant.
- Sub-module msrv32_load_extract: purely combinational lane select plus extend (data, offset, unsigned, size -> 32-bit result).
- Top module: instantiates msrv32_load_extract and holds the output register with the ahb_resp_in hold enable.

Test Plan:
- Reset: assert reset with dmdata = 0x12345678 -> lu_output_out = 0x00000000 with no clock edge needed; stays 0 after release until the first valid edge.
- Byte lanes, dmdata = 0x12345678, ahb_resp_in = 0, size = 00:
  - offset 00 signed -> 0x00000078.
  - offset 01 unsigned -> 0x00000056.
  - offset 10 signed -> 0x00000034.
  - offset 11 unsigned -> 0x00000012.
  - Each result appears one clock after the input change.
- Halfword/word, dmdata = 0x12345678:
  - size 01, offset 00, signed -> 0x00005678.
  - size 01, offset 10, unsigned -> 0x00001234.
  - size 10, offset 00 -> 0x12345678.
  - size 11 -> 0x12345678.
- Sign extension, dmdata = 0x80FF7F80:
  - LB offset 00 -> 0xFFFFFF80; LBU offset 00 -> 0x00000080.
  - LB offset 01 -> 0x0000007F.
  - LH offset 10 -> 0xFFFF80FF; LHU offset 10 -> 0x000080FF.
- Hold: produce 0x12345678 (word load), then set ahb_resp_in = 1 and change dmdata to 0xDEADBEEF -> output stays 0x12345678. Set ahb_resp_in = 0 -> 0xDEADBEEF after 1 clock.
- Misaligned halfword: dmdata = 0x12345678, size 01, offset 01 -> 0x00005678; offset 11 -> 0x00001234.
